// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the writeback commit slice: datapath widths and load funct3 encodings.
package wb_commit_unit_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Load data formatter: picks the addressed byte or halfword from the raw memory word and extends it.
module wb_load_align
    import wb_commit_unit_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Halfwords are selected by addr_lo[1] alone; a misaligned low bit is ignored.
    always_comb begin
        byte_sel = lane[addr_lo];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback stage: merges the MEM->WB pipeline with a one-entry MDU result buffer onto the
// register-file write port, drops x0 writes and requests a stall when the buffer starves.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  mem_valid_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]       mem_result_i,
    input  logic                  mem_is_load_i,
    input  logic [2:0]            mem_funct3_i,
    input  logic [1:0]            mem_addr_lo_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    input  logic                  mdu_valid_i,
    input  logic [REG_ADDR_W-1:0] mdu_rd_i,
    input  logic [XLEN-1:0]       mdu_data_i,
    output logic                  mdu_ready_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic [XLEN-1:0]       RDdata_o,
    output logic                  RegWrite_o,
    output logic                  wb_hold_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic                  wb_valid_reg;
    logic [REG_ADDR_W-1:0] wb_rd_reg;
    logic [XLEN-1:0]       wb_data_reg;
    logic                  buf_valid_reg;
    logic [REG_ADDR_W-1:0] buf_rd_reg;
    logic [XLEN-1:0]       buf_data_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [CNT_W-1:0]      cnt_next;
    logic                  hold_reg;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] mem_data;
    logic            wb_wr;
    logic            buf_wr;
    logic            kill;
    logic            accept;

    wb_load_align u_load_align (
        .funct3  (mem_funct3_i),
        .addr_lo (mem_addr_lo_i),
        .rdata   (mem_rdata_i),
        .data    (load_data)
    );

    assign mem_data = mem_is_load_i ? load_data : mem_result_i;

    // A WB entry targeting x0 is treated as an empty slot so the buffer may use it.
    assign wb_wr  = wb_valid_reg && (wb_rd_reg != '0);
    assign buf_wr = !wb_wr && buf_valid_reg;
    assign kill   = wb_wr && buf_valid_reg && (wb_rd_reg == buf_rd_reg);
    assign accept = mdu_valid_i && !buf_valid_reg;

    assign mdu_ready_o = !buf_valid_reg;
    assign RegWrite_o  = wb_wr || buf_wr;
    assign RDaddr_o    = wb_wr ? wb_rd_reg   : (buf_wr ? buf_rd_reg   : '0);
    assign RDdata_o    = wb_wr ? wb_data_reg : (buf_wr ? buf_data_reg : '0);
    assign wb_hold_o   = hold_reg;

    // Counts cycles the buffered result loses to the pipeline; saturates at the hold threshold.
    always_comb begin
        cnt_next = cnt_reg;
        if (!buf_valid_reg || buf_wr || kill) begin
            cnt_next = '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_reg  <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
            buf_valid_reg <= 1'b0;
            buf_rd_reg    <= '0;
            buf_data_reg  <= '0;
            cnt_reg       <= '0;
            hold_reg      <= 1'b0;
        end else begin
            if (stall_i) begin
                wb_valid_reg <= 1'b0;
            end else begin
                wb_valid_reg <= mem_valid_i;
                wb_rd_reg    <= mem_rd_i;
                wb_data_reg  <= mem_data;
            end

            // Drain and accept are mutually exclusive because ready is low while full.
            if (buf_wr || kill) begin
                buf_valid_reg <= 1'b0;
            end else if (accept && (mdu_rd_i != '0)) begin
                buf_valid_reg <= 1'b1;
                buf_rd_reg    <= mdu_rd_i;
                buf_data_reg  <= mdu_data_i;
            end

            cnt_reg  <= cnt_next;
            hold_reg <= (cnt_next == LIMIT);
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: expected register-file writes are queued as stimulus
// is driven and popped by a monitor as the DUT writes.
module tb_wb_commit_unit;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        mem_valid_i;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_result_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic [1:0]  mem_addr_lo_i;
    logic [31:0] mem_rdata_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        RegWrite_o;
    logic        wb_hold_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    wb_commit_unit #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .mem_valid_i   (mem_valid_i),
        .mem_rd_i      (mem_rd_i),
        .mem_result_i  (mem_result_i),
        .mem_is_load_i (mem_is_load_i),
        .mem_funct3_i  (mem_funct3_i),
        .mem_addr_lo_i (mem_addr_lo_i),
        .mem_rdata_i   (mem_rdata_i),
        .mdu_valid_i   (mdu_valid_i),
        .mdu_rd_i      (mdu_rd_i),
        .mdu_data_i    (mdu_data_i),
        .mdu_ready_o   (mdu_ready_o),
        .RDaddr_o      (RDaddr_o),
        .RDdata_o      (RDdata_o),
        .RegWrite_o    (RegWrite_o),
        .wb_hold_o     (wb_hold_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: every write must match the oldest expectation; idle port must be zero.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            checks++;
            if (RegWrite_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got rd=%0d data=%h, required no write",
                             RDaddr_o, RDdata_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({RDaddr_o, RDdata_o} !== {mon_e.rd, mon_e.data}) begin
                        errors++;
                        $display("FAIL write got rd=%0d data=%h, required rd=%0d data=%h",
                                 RDaddr_o, RDdata_o, mon_e.rd, mon_e.data);
                    end else begin
                        $display("write rd=%0d data=%h ok", RDaddr_o, RDdata_o);
                    end
                end
            end else if (RegWrite_o !== 1'b0 || RDaddr_o !== 5'd0 || RDdata_o !== 32'd0) begin
                errors++;
                $display("FAIL idle_port got we=%b rd=%0d data=%h, required 0/0/0",
                         RegWrite_o, RDaddr_o, RDdata_o);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i       = 1'b0;
        mem_valid_i   = 1'b0;
        mem_rd_i      = 5'd0;
        mem_result_i  = 32'd0;
        mem_is_load_i = 1'b0;
        mem_funct3_i  = 3'd0;
        mem_addr_lo_i = 2'd0;
        mem_rdata_i   = 32'd0;
        mdu_valid_i   = 1'b0;
        mdu_rd_i      = 5'd0;
        mdu_data_i    = 32'd0;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] res);
        mem_valid_i   = v;
        mem_rd_i      = rd;
        mem_result_i  = res;
        mem_is_load_i = 1'b0;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid_i = v;
        mdu_rd_i    = rd;
        mdu_data_i  = d;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, wb_hold_o, mdu_ready_o} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset got we=%b rd=%0d data=%h hold=%b ready=%b, required 0 0 0 0 1",
                     RegWrite_o, RDaddr_o, RDdata_o, wb_hold_o, mdu_ready_o);
        end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_alu();
        set_mem(1'b1, 5'd5, 32'h0000_1234);
        push_exp(5'd5, 32'h0000_1234);
        step();
        set_mem(1'b1, 5'd31, 32'hFFFF_FFFF);
        push_exp(5'd31, 32'hFFFF_FFFF);
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'd5, 32'h0000_1234}) begin
            errors++;
            $display("FAIL alu_latency got we=%b rd=%0d data=%h, required 1 5 00001234",
                     RegWrite_o, RDaddr_o, RDdata_o);
        end
        step();
        set_mem(1'b1, 5'd1, 32'h0);
        push_exp(5'd1, 32'h0);
        step();
        idle_inputs();
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL alu_missing got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [12] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000,
                                  3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b001};
        logic [1:0]  off [12] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1,
                                  2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0};
        logic [31:0] res [12] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                                  32'h80FF7F01, 32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                                  32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01, 32'h00007F01};
        for (int i = 0; i < 12; i++) begin
            set_mem(1'b1, 5'(10 + i), 32'hDEAD_BEEF);
            mem_is_load_i = 1'b1;
            mem_funct3_i  = f3[i];
            mem_addr_lo_i = off[i];
            mem_rdata_i   = 32'h80FF_7F01;
            push_exp(5'(10 + i), res[i]);
            step();
        end
        idle_inputs();
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL loads_missing got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_x0_stall();
        set_mem(1'b1, 5'd0, 32'h0000_0055);
        step();
        set_mem(1'b1, 5'd6, 32'h0000_0066);
        push_exp(5'd6, 32'h0000_0066);
        checks++;
        if (RegWrite_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_write got we=%b, required 0", RegWrite_o);
        end
        step();
        stall_i = 1'b1;
        set_mem(1'b1, 5'd8, 32'h0000_0088);
        checks++;
        if ({RegWrite_o, RDaddr_o} !== {1'b1, 5'd6}) begin
            errors++;
            $display("FAIL stall_capture got we=%b rd=%0d, required 1 6", RegWrite_o, RDaddr_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) begin
                stall_i = 1'b0;
                push_exp(5'd8, 32'h0000_0088);
            end
            checks++;
            if (RegWrite_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble%0d got we=%b rd=%0d, required 0", i, RegWrite_o, RDaddr_o);
            end
        end
        step();
        idle_inputs();
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_missing got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_mdu();
        logic       offer_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [4:0] offer_rd [6] = '{5'd7, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0};
        logic       ready_e  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        push_exp(5'd7, 32'h0000_CAFE);
        push_exp(5'd3, 32'h0000_BEEF);
        for (int i = 0; i < 6; i++) begin
            set_mdu(offer_v[i], offer_rd[i], (i == 0) ? 32'h0000_CAFE : 32'h0000_BEEF);
            checks++;
            if (mdu_ready_o !== ready_e[i]) begin
                errors++;
                $display("FAIL mdu_ready%0d got %b, required %b", i, mdu_ready_o, ready_e[i]);
            end
            step();
        end
        idle_inputs();
        drain();
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mdu_missing got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_kill();
        set_mdu(1'b1, 5'd9, 32'h0000_0999);
        set_mem(1'b1, 5'd9, 32'h0000_1999);
        push_exp(5'd9, 32'h0000_1999);
        step();
        idle_inputs();
        checks++;
        if (mdu_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_buffered got ready=%b, required 0", mdu_ready_o);
        end
        step();
        checks++;
        if (mdu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL kill_cleared got ready=%b, required 1", mdu_ready_o);
        end
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL kill_missing got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_starve();
        logic hold_e;
        set_mdu(1'b1, 5'd10, 32'h0000_A0A0);
        set_mem(1'b1, 5'd1, 32'h0000_0101);
        push_exp(5'd1, 32'h0000_0101);
        step();
        mdu_valid_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_mem(1'b1, 5'(i + 1), 32'h0000_0100 + 32'(i + 1));
            push_exp(5'(i + 1), 32'h0000_0100 + 32'(i + 1));
            hold_e = (i == 5);
            checks++;
            if (wb_hold_o !== hold_e) begin
                errors++;
                $display("FAIL starve_hold_c%0d got %b, required %b", i, wb_hold_o, hold_e);
            end
            step();
        end
        idle_inputs();
        push_exp(5'd10, 32'h0000_A0A0);
        for (int i = 6; i <= 8; i++) begin
            hold_e = (i != 8);
            checks++;
            if (wb_hold_o !== hold_e) begin
                errors++;
                $display("FAIL starve_hold_c%0d got %b, required %b", i, wb_hold_o, hold_e);
            end
            step();
        end
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL starve_missing got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        set_mdu(1'b1, 5'd12, 32'h0000_0C0C);
        set_mem(1'b1, 5'd13, 32'h0000_0D0D);
        step();
        idle_inputs();
        rst_i = 1'b0;
        #1;
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, wb_hold_o, mdu_ready_o} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid got we=%b rd=%0d data=%h hold=%b ready=%b, required 0 0 0 0 1",
                     RegWrite_o, RDaddr_o, RDdata_o, wb_hold_o, mdu_ready_o);
        end
        repeat (2) step();
        rst_i = 1'b1;
        repeat (4) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_queue got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_x0_stall();
        test_mdu();
        test_kill();
        test_starve();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
